// File: rtl/lcd_frame_driver_pkg.sv
// Shared FSM/timer types and KS0108 command bytes for lcd_frame_driver.
// Optional build macro LCD_CLEAR_EN is handled in the interface and top.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISP_ON,
        S_SET_PAGE,
        S_SET_COL,
        S_FETCH,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        T_SETUP,
        T_HIGH,
        T_LOW
    } phase_t;

    localparam logic [7:0] LCD_CMD_DISP_ON = 8'h3F;
    localparam logic [7:0] LCD_CMD_PAGE    = 8'hB8;
    localparam logic [7:0] LCD_CMD_COL     = 8'h40;

    function automatic logic [7:0] page_cmd(input logic [2:0] page);
        return LCD_CMD_PAGE | {5'b0, page};
    endfunction

endpackage

// File: rtl/lcd_frame_driver_if.sv
// Frame-request, frame-buffer and LCD pin bundle for lcd_frame_driver.
// LCD_CLEAR_EN adds the clear_i request qualifier.
interface lcd_frame_driver_if #(
    parameter int NUM_CHIPS = 2,
    parameter int AW        = 10
);
    logic                 start_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 fb_rd_o;
    logic [AW-1:0]        fb_addr_o;
    logic [7:0]           fb_data_i;
    logic [7:0]           lcd_db_o;
    logic                 lcd_dori_o;
    logic                 lcd_rw_o;
    logic                 lcd_en_o;
    logic [NUM_CHIPS-1:0] lcd_cs_o;

`ifdef LCD_CLEAR_EN
    logic                 clear_i;

    modport master (
        input  start_i, clear_i, fb_data_i,
        output busy_o, done_o, fb_rd_o, fb_addr_o,
        output lcd_db_o, lcd_dori_o, lcd_rw_o, lcd_en_o, lcd_cs_o
    );

    modport slave (
        output start_i, clear_i, fb_data_i,
        input  busy_o, done_o, fb_rd_o, fb_addr_o,
        input  lcd_db_o, lcd_dori_o, lcd_rw_o, lcd_en_o, lcd_cs_o
    );
`else
    modport master (
        input  start_i, fb_data_i,
        output busy_o, done_o, fb_rd_o, fb_addr_o,
        output lcd_db_o, lcd_dori_o, lcd_rw_o, lcd_en_o, lcd_cs_o
    );

    modport slave (
        output start_i, fb_data_i,
        input  busy_o, done_o, fb_rd_o, fb_addr_o,
        input  lcd_db_o, lcd_dori_o, lcd_rw_o, lcd_en_o, lcd_cs_o
    );
`endif

endinterface

// File: rtl/lcd_frame_driver_bus_timer.sv
// One LCD write transaction: SETUP, EN_HIGH_CYC high, EN_LOW_CYC low.
// Pins are registered and held for the whole transaction.
module lcd_bus_timer
    import lcd_pkg::*;
#(
    parameter int NUM_CHIPS   = 2,
    parameter int EN_HIGH_CYC = 4,
    parameter int EN_LOW_CYC  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [7:0]           db,
    input  logic                 dori,
    input  logic [NUM_CHIPS-1:0] cs,
    output logic [7:0]           lcd_db,
    output logic                 lcd_dori,
    output logic                 lcd_en,
    output logic [NUM_CHIPS-1:0] lcd_cs,
    output logic                 ack
);

    localparam int CNT_MAX = (EN_HIGH_CYC > EN_LOW_CYC) ? EN_HIGH_CYC : EN_LOW_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HIGH_LAST = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(EN_LOW_CYC - 1);

    logic          active;
    phase_t        phase;
    logic [CW-1:0] cnt;

    // A new req in the ack cycle chains transactions with no idle gap.
    assign ack = active && (phase == T_LOW) && (cnt == LOW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            phase    <= T_SETUP;
            cnt      <= '0;
            lcd_db   <= '0;
            lcd_dori <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_cs   <= '0;
        end else if (req) begin
            active   <= 1'b1;
            phase    <= T_SETUP;
            cnt      <= '0;
            lcd_db   <= db;
            lcd_dori <= dori;
            lcd_en   <= 1'b0;
            lcd_cs   <= cs;
        end else if (active) begin
            unique case (phase)
                T_SETUP: begin
                    phase  <= T_HIGH;
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                end
                T_HIGH: begin
                    if (cnt == HIGH_LAST) begin
                        phase  <= T_LOW;
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                T_LOW: begin
                    if (cnt == LOW_LAST) begin
                        active   <= 1'b0;
                        lcd_db   <= '0;
                        lcd_dori <= 1'b0;
                        lcd_cs   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    active <= 1'b0;
                    lcd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_driver.sv
// Full-frame refresh for dual-controller KS0108-class LCDs.
// Build macro LCD_CLEAR_EN adds clear_i for zero-fill frames.
module lcd_frame_driver
    import lcd_pkg::*;
#(
    parameter int NUM_CHIPS   = 2,
    parameter int PAGES       = 8,
    parameter int COLS        = 64,
    parameter int EN_HIGH_CYC = 4,
    parameter int EN_LOW_CYC  = 4
) (
    input logic                clk,
    input logic                rst,
    lcd_frame_driver_if.master bus
);

    localparam int DEPTH = NUM_CHIPS * PAGES * COLS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CHW   = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
    localparam logic [CHW-1:0] CHIP_LAST = CHW'(NUM_CHIPS - 1);
    localparam logic [2:0]     PAGE_LAST = 3'(PAGES - 1);
    localparam logic [5:0]     COL_LAST  = 6'(COLS - 1);

    if (NUM_CHIPS < 1 || PAGES < 1 || PAGES > 8 || COLS < 1 || COLS > 64 ||
        EN_HIGH_CYC < 1 || EN_LOW_CYC < 1) begin : g_param_check
        $error("lcd_frame_driver: parameter out of range");
    end

    state_t               state;
    state_t               state_n;
    logic                 start_q;
    logic                 start_edge;
    logic                 clear_mode;
    logic [CHW-1:0]       chip;
    logic [CHW-1:0]       chip_n;
    logic [2:0]           page;
    logic [2:0]           page_n;
    logic [5:0]           col;
    logic [5:0]           col_n;
    logic                 req;
    logic                 req_dori;
    logic [7:0]           req_db;
    logic [NUM_CHIPS-1:0] req_cs;
    logic                 ack;

    assign start_edge = (state == S_IDLE) && bus.start_i && !start_q;

`ifdef LCD_CLEAR_EN
    logic clear_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clear_q <= 1'b0;
        end else if (start_edge) begin
            clear_q <= bus.clear_i;
        end
    end

    assign clear_mode = clear_q;
`else
    assign clear_mode = 1'b0;
`endif

    // Next-state and the transaction to launch on this edge, if any.
    always_comb begin
        state_n  = state;
        chip_n   = chip;
        page_n   = page;
        col_n    = col;
        req      = 1'b0;
        req_db   = 8'h00;
        req_dori = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_n = S_DISP_ON;
                    req     = 1'b1;
                    req_db  = LCD_CMD_DISP_ON;
                end
            end
            S_DISP_ON: begin
                if (ack) begin
                    state_n = S_SET_PAGE;
                    req     = 1'b1;
                    req_db  = page_cmd(page);
                end
            end
            S_SET_PAGE: begin
                if (ack) begin
                    state_n = S_SET_COL;
                    req     = 1'b1;
                    req_db  = LCD_CMD_COL;
                end
            end
            S_SET_COL: begin
                if (ack) begin
                    if (clear_mode) begin
                        state_n  = S_WRITE;
                        req      = 1'b1;
                        req_dori = 1'b1;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_n = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_n  = S_WRITE;
                req      = 1'b1;
                req_dori = 1'b1;
                req_db   = bus.fb_data_i;
            end
            S_WRITE: begin
                if (ack) begin
                    if (col != COL_LAST) begin
                        col_n = col + 6'd1;
                        if (clear_mode) begin
                            state_n  = S_WRITE;
                            req      = 1'b1;
                            req_dori = 1'b1;
                        end else begin
                            state_n = S_FETCH;
                        end
                    end else if (page != PAGE_LAST) begin
                        col_n   = '0;
                        page_n  = page + 3'd1;
                        state_n = S_SET_PAGE;
                        req     = 1'b1;
                        req_db  = page_cmd(page_n);
                    end else if (chip != CHIP_LAST) begin
                        col_n   = '0;
                        page_n  = '0;
                        chip_n  = chip + 1'b1;
                        state_n = S_DISP_ON;
                        req     = 1'b1;
                        req_db  = LCD_CMD_DISP_ON;
                    end else begin
                        col_n   = '0;
                        page_n  = '0;
                        chip_n  = '0;
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign req_cs = NUM_CHIPS'(1) << chip_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            start_q       <= 1'b0;
            chip          <= '0;
            page          <= '0;
            col           <= '0;
            bus.busy_o    <= 1'b0;
            bus.done_o    <= 1'b0;
            bus.fb_rd_o   <= 1'b0;
            bus.fb_addr_o <= '0;
        end else begin
            state       <= state_n;
            start_q     <= bus.start_i;
            chip        <= chip_n;
            page        <= page_n;
            col         <= col_n;
            bus.busy_o  <= (state_n != S_IDLE) && (state_n != S_DONE);
            bus.done_o  <= (state_n == S_DONE);
            bus.fb_rd_o <= (state_n == S_FETCH);
            if (state_n == S_FETCH) begin
                bus.fb_addr_o <= AW'((32'(chip_n) * 32'(PAGES) + 32'(page_n)) *
                                     32'(COLS) + 32'(col_n));
            end
        end
    end

    assign bus.lcd_rw_o = 1'b0;

    lcd_bus_timer #(
        .NUM_CHIPS  (NUM_CHIPS),
        .EN_HIGH_CYC(EN_HIGH_CYC),
        .EN_LOW_CYC (EN_LOW_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .db      (req_db),
        .dori    (req_dori),
        .cs      (req_cs),
        .lcd_db  (bus.lcd_db_o),
        .lcd_dori(bus.lcd_dori_o),
        .lcd_en  (bus.lcd_en_o),
        .lcd_cs  (bus.lcd_cs_o),
        .ack     (ack)
    );

endmodule
